// File: rtl/cr_pkg.sv
// Shared types, limits and the BCD clamp used by the cronometro countdown controller.
// Optional build macro: CR_ALARM_TIMEOUT_EN (see cr_timer_ctrl).
package cr_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } cr_state_t;

   localparam logic [7:0] CR_MAX_SEG  = 8'h59;
   localparam logic [7:0] CR_MAX_MIN  = 8'h59;
   localparam logic [7:0] CR_MAX_HORA = 8'h23;

   // Any non-decimal digit or out-of-range value saturates to the field limit.
   function automatic logic [7:0] bcd_clamp(input logic [7:0] val, input logic [7:0] max);
      if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val > max)) begin
         return max;
      end
      return val;
   endfunction

endpackage

// File: rtl/cr_bcd_dec.sv
// Combinational two-digit BCD decrement with borrow chaining; wraps 00 to max_wrap.
module cr_bcd_dec (
   input  logic [7:0] value,
   input  logic [7:0] max_wrap,
   input  logic       borrow_in,
   output logic [7:0] value_next,
   output logic       borrow_out
);

   always_comb begin
      value_next = value;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (value == 8'h00) begin
            value_next = max_wrap;
            borrow_out = 1'b1;
         end else if (value[3:0] == 4'h0) begin
            value_next = {value[7:4] - 4'd1, 4'h9};
         end else begin
            value_next = {value[7:4], value[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/cr_timer_ctrl.sv
// Countdown controller: holds hh:mm:ss in BCD, decrements on tick_1hz and strobes the display regs.
// Build macro CR_ALARM_TIMEOUT_EN adds an alarm auto-clear after ALARM_SECS ticks in DONE.
module cr_timer_ctrl
   import cr_pkg::*;
#(
   parameter int unsigned ALARM_SECS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       load,
   input  logic [7:0] set_hora,
   input  logic [7:0] set_min,
   input  logic [7:0] set_seg,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic       alarm_ack,
   output logic [7:0] dato_cr_hora,
   output logic [7:0] dato_cr_min,
   output logic [7:0] dato_cr_seg,
   output logic       en_cr_hora,
   output logic       en_cr_min,
   output logic       en_cr_seg,
   output logic       running,
   output logic       alarm
);

   cr_state_t  state_q, state_d;
   logic [7:0] hora_q, hora_d, min_q, min_d, seg_q, seg_d;
   logic       en_h_q, en_h_d, en_m_q, en_m_d, en_s_q, en_s_d;
   logic       run_q, run_d;
   logic       alarm_q, alarm_d;

   logic [7:0] seg_dec, min_dec, hora_dec;
   logic       seg_borrow, min_borrow, hora_borrow;
   logic       cnt_zero;

`ifdef CR_ALARM_TIMEOUT_EN
   localparam int unsigned AW = $clog2(ALARM_SECS + 1);
   logic [AW-1:0] acnt_q, acnt_d;
`endif

   cr_bcd_dec u_dec_seg (
      .value      (seg_q),
      .max_wrap   (CR_MAX_SEG),
      .borrow_in  (1'b1),
      .value_next (seg_dec),
      .borrow_out (seg_borrow)
   );

   cr_bcd_dec u_dec_min (
      .value      (min_q),
      .max_wrap   (CR_MAX_MIN),
      .borrow_in  (seg_borrow),
      .value_next (min_dec),
      .borrow_out (min_borrow)
   );

   cr_bcd_dec u_dec_hora (
      .value      (hora_q),
      .max_wrap   (CR_MAX_HORA),
      .borrow_in  (min_borrow),
      .value_next (hora_dec),
      .borrow_out (hora_borrow)
   );

   assign cnt_zero = (hora_q == 8'h00) && (min_q == 8'h00) && (seg_q == 8'h00);

   always_comb begin
      state_d = state_q;
      hora_d  = hora_q;
      min_d   = min_q;
      seg_d   = seg_q;
      en_h_d  = 1'b0;
      en_m_d  = 1'b0;
      en_s_d  = 1'b0;
      alarm_d = alarm_q & ~alarm_ack;
`ifdef CR_ALARM_TIMEOUT_EN
      acnt_d  = acnt_q;
`endif

      if (stop) begin
         hora_d  = 8'h00;
         min_d   = 8'h00;
         seg_d   = 8'h00;
         {en_h_d, en_m_d, en_s_d} = 3'b111;
         alarm_d = 1'b0;
         state_d = StIdle;
      end else if (load) begin
         if ((state_q == StIdle) || (state_q == StDone)) begin
            hora_d  = bcd_clamp(set_hora, CR_MAX_HORA);
            min_d   = bcd_clamp(set_min, CR_MAX_MIN);
            seg_d   = bcd_clamp(set_seg, CR_MAX_SEG);
            {en_h_d, en_m_d, en_s_d} = 3'b111;
            alarm_d = 1'b0;
            state_d = StIdle;
         end
      end else if (pause) begin
         if (state_q == StRun) begin
            state_d = StPause;
         end
      end else if (start) begin
         if (((state_q == StIdle) || (state_q == StPause)) && !cnt_zero) begin
            state_d = StRun;
         end
      end else if (tick_1hz) begin
         // A full borrow out of hours means the count was already zero; hold it.
         if ((state_q == StRun) && !hora_borrow) begin
            hora_d = hora_dec;
            min_d  = min_dec;
            seg_d  = seg_dec;
            en_h_d = (hora_dec != hora_q);
            en_m_d = (min_dec != min_q);
            en_s_d = (seg_dec != seg_q);
            if ((hora_dec == 8'h00) && (min_dec == 8'h00) && (seg_dec == 8'h00)) begin
               state_d = StDone;
               alarm_d = 1'b1;
`ifdef CR_ALARM_TIMEOUT_EN
               acnt_d  = '0;
`endif
            end
         end
`ifdef CR_ALARM_TIMEOUT_EN
         else if ((state_q == StDone) && alarm_q) begin
            if (acnt_q == AW'(ALARM_SECS - 1)) begin
               alarm_d = 1'b0;
            end
            acnt_d = acnt_q + AW'(1);
         end
`endif
      end

      run_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         hora_q  <= 8'h00;
         min_q   <= 8'h00;
         seg_q   <= 8'h00;
         en_h_q  <= 1'b0;
         en_m_q  <= 1'b0;
         en_s_q  <= 1'b0;
         run_q   <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hora_q  <= hora_d;
         min_q   <= min_d;
         seg_q   <= seg_d;
         en_h_q  <= en_h_d;
         en_m_q  <= en_m_d;
         en_s_q  <= en_s_d;
         run_q   <= run_d;
         alarm_q <= alarm_d;
      end
   end

`ifdef CR_ALARM_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acnt_q <= '0;
      end else begin
         acnt_q <= acnt_d;
      end
   end
`endif

   assign dato_cr_hora = hora_q;
   assign dato_cr_min  = min_q;
   assign dato_cr_seg  = seg_q;
   assign en_cr_hora   = en_h_q;
   assign en_cr_min    = en_m_q;
   assign en_cr_seg    = en_s_q;
   assign running      = run_q;
   assign alarm        = alarm_q;

endmodule
